pipe_scoreboard: RTL and testbench



---
 rtl/pipe_scoreboard_if.sv | 34 +++
 rtl/pipe_scoreboard.sv | 125 ++++++++++++
 tb/tb_pipe_scoreboard.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/pipe_scoreboard_if.sv
// rtl/pipe_scoreboard_if.sv - issue/hazard bundle between ID stage and pipe_scoreboard
interface pipe_scoreboard_if #(
  parameter int DEPTH = 3,
  parameter int NREG  = 16
);
  localparam int RW = $clog2(NREG);
  localparam int SW = $clog2(DEPTH + 1);

  logic          issue_valid;
  logic          issue_wr;
  logic          issue_load;
  logic [RW-1:0] issue_dst;
  logic          src1_valid;
  logic          src2_valid;
  logic [RW-1:0] src1;
  logic [RW-1:0] src2;
  logic          flush;
  logic          stall;
  logic [SW-1:0] fwd_sel1;
  logic [SW-1:0] fwd_sel2;
  logic [SW-1:0] busy_cnt;

  modport master (
    output issue_valid, issue_wr, issue_load, issue_dst,
    output src1_valid, src2_valid, src1, src2, flush,
    input  stall, fwd_sel1, fwd_sel2, busy_cnt
  );

  modport slave (
    input  issue_valid, issue_wr, issue_load, issue_dst,
    input  src1_valid, src2_valid, src1, src2, flush,
    output stall, fwd_sel1, fwd_sel2, busy_cnt
  );
endinterface

// File: rtl/pipe_scoreboard.sv
// rtl/pipe_scoreboard.sv - in-order pipeline hazard scoreboard; SCOREBOARD_FWD_EN selects the forwarding build
module pipe_scoreboard #(
  parameter int DEPTH     = 3,
  parameter int NREG      = 16,
  parameter int LOAD_SLOT = 2
) (
  input logic              clk,
  input logic              rst,
  pipe_scoreboard_if.slave sb
);
  localparam int RW = $clog2(NREG);
  localparam int SW = $clog2(DEPTH + 1);

  if (DEPTH < 2 || LOAD_SLOT < 1 || LOAD_SLOT > DEPTH - 1 || NREG < 2) begin : g_param_err
    $fatal(1, "pipe_scoreboard: illegal DEPTH/LOAD_SLOT/NREG");
  end

  // Slot k holds the writer that is k+1 stages past issue; slot 0 is EXE, slot DEPTH-1 is WB.
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [RW-1:0]    dst_q [DEPTH];
  logic [RW-1:0]    dst_d [DEPTH];
  logic [SW-1:0]    busy_cnt_q, busy_cnt_d;
  logic             haz1, haz2;
  logic             stall;
  logic             accept;

`ifdef SCOREBOARD_FWD_EN
  logic [DEPTH-1:0] load_q, load_d;
  logic [SW-1:0]    sel1, sel2;
  logic [SW-1:0]    fwd_sel1_q, fwd_sel1_d;
  logic [SW-1:0]    fwd_sel2_q, fwd_sel2_d;
`else
  logic             unused_load;
  assign unused_load = sb.issue_load;
`endif

  // Source lookup: scan oldest to youngest so the youngest matching slot overrides older ones
  always_comb begin
    haz1 = 1'b0;
    haz2 = 1'b0;
`ifdef SCOREBOARD_FWD_EN
    sel1 = '0;
    sel2 = '0;
`endif
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (sb.src1_valid && valid_q[k] && (dst_q[k] == sb.src1)) begin
`ifdef SCOREBOARD_FWD_EN
        // A load only has data from LOAD_SLOT on; the consumer reaches EXE when the producer is at k+1.
        haz1 = load_q[k] && (k + 1 < LOAD_SLOT);
        sel1 = (k <= DEPTH - 2) ? SW'(k + 1) : '0;
`else
        // The WB slot writes the register file before it is read, so only earlier slots block.
        haz1 = (k <= DEPTH - 2);
`endif
      end
      if (sb.src2_valid && valid_q[k] && (dst_q[k] == sb.src2)) begin
`ifdef SCOREBOARD_FWD_EN
        haz2 = load_q[k] && (k + 1 < LOAD_SLOT);
        sel2 = (k <= DEPTH - 2) ? SW'(k + 1) : '0;
`else
        haz2 = (k <= DEPTH - 2);
`endif
      end
    end
  end

  // Flush overrides any hazard; slots are empty in reset, the rst term just makes that explicit.
  assign stall  = rst & sb.issue_valid & ~sb.flush & (haz1 | haz2);
  assign accept = sb.issue_valid & ~stall & ~sb.flush;

  // Next slot contents: the shift never stops, slot 0 takes an accepted writer or a bubble
  always_comb begin
    valid_d  = {valid_q[DEPTH-2:0], accept & sb.issue_wr};
    dst_d[0] = sb.issue_dst;
    for (int k = 1; k < DEPTH; k++) begin
      dst_d[k] = dst_q[k-1];
    end
    busy_cnt_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      busy_cnt_d = busy_cnt_d + SW'(valid_d[k]);
    end
`ifdef SCOREBOARD_FWD_EN
    load_d     = {load_q[DEPTH-2:0], sb.issue_load};
    fwd_sel1_d = accept ? sel1 : '0;
    fwd_sel2_d = accept ? sel2 : '0;
`endif
  end

  // Slot pipeline and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= '0;
      busy_cnt_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        dst_q[k] <= '0;
      end
`ifdef SCOREBOARD_FWD_EN
      load_q     <= '0;
      fwd_sel1_q <= '0;
      fwd_sel2_q <= '0;
`endif
    end else begin
      valid_q    <= valid_d;
      busy_cnt_q <= busy_cnt_d;
      for (int k = 0; k < DEPTH; k++) begin
        dst_q[k] <= dst_d[k];
      end
`ifdef SCOREBOARD_FWD_EN
      load_q     <= load_d;
      fwd_sel1_q <= fwd_sel1_d;
      fwd_sel2_q <= fwd_sel2_d;
`endif
    end
  end

  assign sb.stall    = stall;
  assign sb.busy_cnt = busy_cnt_q;
`ifdef SCOREBOARD_FWD_EN
  assign sb.fwd_sel1 = fwd_sel1_q;
  assign sb.fwd_sel2 = fwd_sel2_q;
`else
  assign sb.fwd_sel1 = '0;
  assign sb.fwd_sel2 = '0;
`endif
endmodule

// File: tb/tb_pipe_scoreboard.sv
// tb/tb_pipe_scoreboard.sv - directed self-checking bench for pipe_scoreboard (both SCOREBOARD_FWD_EN builds)
module tb_pipe_scoreboard;
  localparam int DEPTH     = 3;
  localparam int NREG      = 16;
  localparam int LOAD_SLOT = 2;
  localparam int RW        = $clog2(NREG);
`ifdef SCOREBOARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   st;

  always #5 clk = ~clk;

  pipe_scoreboard_if #(.DEPTH(DEPTH), .NREG(NREG)) sb ();

  pipe_scoreboard #(.DEPTH(DEPTH), .NREG(NREG), .LOAD_SLOT(LOAD_SLOT)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int v, input int wr, input int ld, input int dst,
                       input int s1v, input int s1, input int s2v, input int s2, input int fl);
    sb.issue_valid = (v != 0);
    sb.issue_wr    = (wr != 0);
    sb.issue_load  = (ld != 0);
    sb.issue_dst   = RW'(dst);
    sb.src1_valid  = (s1v != 0);
    sb.src1        = RW'(s1);
    sb.src2_valid  = (s2v != 0);
    sb.src2        = RW'(s2);
    sb.flush       = (fl != 0);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Hold the driven instruction until accepted; returns the number of stall cycles seen.
  task automatic issue_wait(output int stalls);
    stalls = 0;
    #1;
    while (sb.stall === 1'b1 && stalls < 8) begin
      @(posedge clk);
      #1;
      stalls++;
    end
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic drain();
    idle();
    repeat (DEPTH) tick();
    check_eq("drain_busy", 32'(sb.busy_cnt), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: outputs clear and stall held low even with a would-be hazard presented
    rst = 1'b0;
    drive(1, 1, 0, 3, 1, 3, 1, 3, 0);
    #2;
    check_eq("rst_stall", 32'(sb.stall), 0);
    check_eq("rst_busy", 32'(sb.busy_cnt), 0);
    check_eq("rst_fwd1", 32'(sb.fwd_sel1), 0);
    check_eq("rst_fwd2", 32'(sb.fwd_sel2), 0);
    idle();
    @(negedge clk);
    #1 rst = 1'b1;
    tick();

    // ALU producer r3, consumer reads r3 on both sources
    drive(1, 1, 0, 3, 0, 0, 0, 0, 0);
    tick();
    check_eq("add_busy", 32'(sb.busy_cnt), 1);
    drive(1, 0, 0, 6, 1, 3, 1, 3, 0);
    issue_wait(st);
    check_eq("alu_use_stalls", st, FWD ? 0 : 2);
    check_eq("alu_use_fwd1", 32'(sb.fwd_sel1), FWD ? 1 : 0);
    check_eq("alu_use_fwd2", 32'(sb.fwd_sel2), FWD ? 1 : 0);
    check_eq("alu_use_busy", 32'(sb.busy_cnt), FWD ? 1 : 0);
    drain();
    check_eq("idle_fwd1", 32'(sb.fwd_sel1), 0);

    // Load r4, consumer reads r4 on src2
    drive(1, 1, 1, 4, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 1, 9, 1, 4, 0);
    issue_wait(st);
    check_eq("load_use_stalls", st, FWD ? 1 : 2);
    check_eq("load_use_fwd2", 32'(sb.fwd_sel2), FWD ? 2 : 0);
    check_eq("load_use_fwd1", 32'(sb.fwd_sel1), 0);
    check_eq("load_use_busy", 32'(sb.busy_cnt), FWD ? 1 : 0);
    drain();

    // Two writers of r1 back to back, then a writer of r7 that reads r1
    drive(1, 1, 0, 1, 0, 0, 0, 0, 0);
    tick();
    check_eq("wr_r1a_busy", 32'(sb.busy_cnt), 1);
    drive(1, 1, 0, 1, 0, 0, 0, 0, 0);
    tick();
    check_eq("wr_r1b_busy", 32'(sb.busy_cnt), 2);
    drive(1, 1, 0, 7, 1, 1, 0, 0, 0);
    issue_wait(st);
    check_eq("youngest_stalls", st, FWD ? 0 : 2);
    check_eq("youngest_fwd1", 32'(sb.fwd_sel1), FWD ? 1 : 0);
    check_eq("youngest_busy", 32'(sb.busy_cnt), FWD ? 3 : 1);
    drain();

    // Load-use hazard killed by flush in the same cycle
    drive(1, 1, 1, 4, 0, 0, 0, 0, 0);
    tick();
    drive(1, 1, 0, 8, 1, 4, 0, 0, 1);
    #1;
    check_eq("flush_stall", 32'(sb.stall), 0);
    tick();
    idle();
    check_eq("flush_busy", 32'(sb.busy_cnt), 1);
    check_eq("flush_fwd1", 32'(sb.fwd_sel1), 0);
    drain();

    // Three writers in flight, then reset pulsed between edges
    drive(1, 1, 0, 2, 0, 0, 0, 0, 0);
    tick();
    drive(1, 1, 0, 3, 0, 0, 0, 0, 0);
    tick();
    drive(1, 1, 0, 10, 1, 3, 0, 0, 0);
    issue_wait(st);
    check_eq("three_busy", 32'(sb.busy_cnt), FWD ? 3 : 1);
    check_eq("three_fwd1", 32'(sb.fwd_sel1), FWD ? 1 : 0);
    drive(1, 0, 0, 0, 1, 10, 0, 0, 0);
    #1 rst = 1'b0;
    #1;
    check_eq("midrst_busy", 32'(sb.busy_cnt), 0);
    check_eq("midrst_fwd1", 32'(sb.fwd_sel1), 0);
    check_eq("midrst_stall", 32'(sb.stall), 0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check_eq("postrst_stall", 32'(sb.stall), 0);
    tick();
    idle();
    check_eq("postrst_fwd1", 32'(sb.fwd_sel1), 0);
    check_eq("postrst_busy", 32'(sb.busy_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
